// File: rtl/seq_divider.sv
// Sequential restoring divider: WP-bit dividend by WM-bit divisor, one quotient
// bit per clock, MSB first, with a start/busy/done handshake.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start; operands are latched on the accepting edge
// CALC  | one restoring iteration per edge, exactly WP iterations
// DONE  | results are registered; the next edge returns to IDLE
module seq_divider #(
    parameter int WP = 8,
    parameter int WM = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [WP-1:0] p,
    input  logic [WM-1:0] m,
    output logic          busy,
    output logic          done,
    output logic [WP-1:0] q,
    output logic [WM-1:0] r,
    output logic          dz
);

    localparam int CW = $clog2(WP) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [WP-1:0] dReg;
    logic [WM-1:0] mReg;
    logic [WM:0]   rReg;
    logic [CW-1:0] cnt;

    logic [WM:0]   tVal;
    logic          qBit;
    logic [WM:0]   rNext;
    logic [WP-1:0] dNext;

    // Bit WM of the trial value is only ever a transient; the restore keeps R < M.
    always_comb begin
        tVal  = {rReg[WM-1:0], dReg[WP-1]};
        qBit  = (tVal >= {1'b0, mReg});
        rNext = qBit ? (tVal - {1'b0, mReg}) : tVal;
        dNext = {dReg[WP-2:0], qBit};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dReg  <= '0;
            mReg  <= '0;
            rReg  <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
            done  <= 1'b0;
        end else begin
            // done trails the DONE state by one cycle, so it shows in the IDLE
            // cycle that can already accept the next start.
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        dReg <= p;
                        mReg <= m;
                        rReg <= '0;
                        cnt  <= '0;
                        if (m == '0) begin
                            state <= DONE;
                            q     <= '1;
                            r     <= '0;
                            dz    <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rReg <= rNext;
                    dReg <= dNext;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WP - 1)) begin
                        state <= DONE;
                        q     <= dNext;
                        r     <= rNext[WM-1:0];
                        dz    <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a
// monitor pops and compares on every done pulse.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] p;
    logic [3:0] m;
    logic       busy;
    logic       done;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;

    typedef struct {
        int p;
        int m;
        int q;
        int r;
        int dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   doneSeen = 0;
    int   opsIssued = 0;

    seq_divider #(.WP(8), .WM(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .p     (p),
        .m     (m),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            doneSeen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with q=%0d r=%0d, expected none", q, r);
            end else begin
                e = sb.pop_front();
                chk("q", int'(q), e.q);
                chk("r", int'(r), e.r);
                chk("dz", int'(dz), e.dz);
                if (e.m != 0) begin
                    chk("q*m+r", int'(q) * e.m + int'(r), e.p);
                    chk("r<m", int'(int'(r) < e.m), 1);
                end
            end
        end
    end

    task automatic pushExp(input int pv, input int mv, input int qv, input int rv, input int dzv);
        exp_t e;
        e.p = pv; e.m = mv; e.q = qv; e.r = rv; e.dz = dzv;
        sb.push_back(e);
        opsIssued++;
    endtask

    task automatic waitDone(input int expLat, input string name);
        int n;
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done after %0d edges, expected %0d", name, n, expLat);
        end else begin
            chk({name, "_latency"}, n, expLat);
            chk({name, "_busy_low_at_done"}, int'(busy), 0);
        end
    endtask

    // Called #1 after an edge; start is accepted on the following edge.
    task automatic runOp(input int pv, input int mv, input int qv, input int rv,
                         input int dzv, input int lat, input string name);
        p = 8'(pv);
        m = 4'(mv);
        start = 1'b1;
        pushExp(pv, mv, qv, rv, dzv);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_busy"}, int'(busy), 1);
        // Count from edge 0; the first edge after it is 1.
        if (!done) begin
            @(posedge clk);
            #1;
        end
        waitDone(lat, name);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        p = '0;
        m = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_dz", int'(dz), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runOp(200, 7, 28, 4, 0, 9, "op200_7");
        @(posedge clk);
        #1;
        chk("done_drops", int'(done), 0);
        chk("busy_idle", int'(busy), 0);

        runOp(255, 1, 255, 0, 0, 9, "op255_1");
        runOp(13, 15, 0, 13, 0, 9, "op13_15");
        runOp(255, 15, 17, 0, 0, 9, "op255_15");
        runOp(0, 9, 0, 0, 0, 9, "op0_9");

        runOp(77, 0, 255, 0, 1, 1, "dz77");
        runOp(9, 3, 3, 0, 0, 9, "op9_3");

        // start held high with operands churning during the operation
        p = 8'd200;
        m = 4'd7;
        start = 1'b1;
        pushExp(200, 7, 28, 4, 0);
        @(posedge clk);
        #1;
        begin
            int n;
            n = 0;
            while (!done && n < 40) begin
                p = 8'($urandom);
                m = 4'($urandom);
                @(posedge clk);
                #1;
                n++;
            end
            chk("hold_latency", n, 9);
        end
        p = 8'd100;
        m = 4'd6;
        pushExp(100, 6, 16, 4, 0);
        @(posedge clk);
        #1;
        chk("hold_next_accept_busy", int'(busy), 1);
        p = 8'd3;
        m = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(9, "hold_second");
        repeat (3) @(posedge clk);
        #1;

        // asynchronous reset in the middle of an operation
        p = 8'd200;
        m = 4'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_q", int'(q), 0);
        chk("arst_r", int'(r), 0);
        chk("arst_dz", int'(dz), 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("arst_no_done", int'(done), 0);
        runOp(100, 6, 16, 4, 0, 9, "op100_6");

        for (int pi = 0; pi < 256; pi++) begin
            for (int mi = 1; mi < 16; mi++) begin
                runOp(pi, mi, pi / mi, pi % mi, 0, 9, "exh");
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_count", doneSeen, opsIssued);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
